// File: rtl/nd_event_counter.sv
// Glitch-filtered event counter: synchronises an asynchronous gate output, debounces it,
// emits edge pulses and keeps a saturating count of qualified falling edges.
module nd_event_counter #(
  parameter int   WIDTH  = 8,
  parameter int   FILTER = 3,
  parameter logic INIT   = 1'b1
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             D,
  input  logic             SP,
  input  logic             SCLR,
  input  logic [WIDTH-1:0] THR,
  output logic             L,
  output logic             FALL,
  output logic             RISE,
  output logic [WIDTH-1:0] Q,
  output logic             OVF,
  output logic             HIT
);

  localparam int               QCW     = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [QCW-1:0]   QC_LAST = QCW'(FILTER - 1);
  localparam logic [WIDTH-1:0] Q_MAX   = {WIDTH{1'b1}};

  logic             s1;
  logic             s2;
  logic [QCW-1:0]   qc;
  logic [QCW-1:0]   qc_next;
  logic             l_next;
  logic             fall_next;
  logic             rise_next;
  logic             evt;
  logic [WIDTH-1:0] q_next;
  logic             ovf_next;
  logic             hit_next;

  // Two-flop synchroniser; D is free-running and may be metastable at s1.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      s1 <= INIT;
      s2 <= INIT;
    end else begin
      s1 <= D;
      s2 <= s1;
    end
  end

  // Qualification: s2 must disagree with L on FILTER consecutive edges before L follows it;
  // any agreeing sample restarts the count.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    qc_next = '0;
    l_next  = L;
    if (s2 != L) begin
      if (qc == QC_LAST) begin
        l_next = s2;
      end else begin
        qc_next = qc + QCW'(1);
      end
    end
  end

  assign fall_next = L & ~l_next;
  assign rise_next = ~L & l_next;
  assign evt       = fall_next & SP;

  // Saturating count; a synchronous clear wins over a coincident event.
  always_comb begin
    q_next   = Q;
    ovf_next = OVF;
    if (SCLR) begin
      q_next   = '0;
      ovf_next = 1'b0;
    end else if (evt) begin
      if (Q == Q_MAX) begin
        ovf_next = 1'b1;
      end else begin
        q_next = Q + WIDTH'(1);
      end
    end
    hit_next = (q_next >= THR);
  end

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      qc   <= '0;
      L    <= INIT;
      FALL <= 1'b0;
      RISE <= 1'b0;
    end else begin
      qc   <= qc_next;
      L    <= l_next;
      FALL <= fall_next;
      RISE <= rise_next;
    end
  end

  // HIT is compared against the next count so it moves on the same edge as Q.
  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      Q   <= '0;
      OVF <= 1'b0;
      HIT <= 1'b0;
    end else begin
      Q   <= q_next;
      OVF <= ovf_next;
      HIT <= hit_next;
    end
  end

endmodule
